// File: rtl/tetris_key_debounce_repeat.sv
// ---------------------------------------------------------------------------
// tetris_key_debounce_repeat
//
// Conditions one raw active-low push-button for a Tetris control PIO.
// The key is synchronised, debounced, and then given DAS-style auto-repeat:
// while the key is held, btn_out is briefly pulsed high so the PIO's
// falling-edge capture sees a fresh press every REPEAT_PERIOD cycles.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   key_n      raw button, asynchronous, 0 = pressed, bouncy
//   repeat_en  1 = auto-repeat enabled (sampled every cycle)
//   btn_out    to PIO in_port: idle 1, 0 while held, 1-gaps on repeat
//   pressed    debounced level, 1 = pressed (no repeat gaps)
// ---------------------------------------------------------------------------
module tetris_key_debounce_repeat #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 15000000,
   parameter int REPEAT_PERIOD   = 5000000,
   parameter int GAP_CYCLES      = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n,
   input  logic repeat_en,
   output logic btn_out,
   output logic pressed
);

   localparam int MAX_A = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int MAX_T = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
   localparam int TW    = $clog2(MAX_T + 1);
   localparam int DW    = $clog2(DEBOUNCE_CYCLES);

   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] DELAY_LOAD = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] RPT_LOAD   = TW'(REPEAT_PERIOD - GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_GAP,
      ST_RPT
   } state_t;

   logic          s1_q;
   logic          sync_q;
   logic          stable_q, stable_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          btn_out_q, btn_out_d;
   logic          pressed_q, pressed_d;

   // Debounce: the synced key must disagree with the stable value for
   // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts.
   always_comb begin
      stable_d  = stable_q;
      deb_cnt_d = '0;
      if (sync_q != stable_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            stable_d = sync_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
         end
      end
   end

   // Repeat FSM. Release wins over any timer expiry. In HOLD/RPT with
   // repeat disabled the timer parks at zero, so re-enabling repeat
   // starts a gap on the very next cycle.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      if (stable_q) begin
         state_d = ST_IDLE;
         timer_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_HOLD;
               timer_d = DELAY_LOAD;
            end
            ST_HOLD, ST_RPT: begin
               if (timer_q == '0) begin
                  if (repeat_en) begin
                     state_d = ST_GAP;
                     timer_d = GAP_LOAD;
                  end
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            ST_GAP: begin
               if (timer_q == '0) begin
                  state_d = ST_RPT;
                  timer_d = RPT_LOAD;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               timer_d = '0;
            end
         endcase
      end
      // Output registered alongside the state so it changes on the same edge.
      btn_out_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
      pressed_d = ~stable_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q      <= 1'b1;
         sync_q    <= 1'b1;
         stable_q  <= 1'b1;
         deb_cnt_q <= '0;
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         btn_out_q <= 1'b1;
         pressed_q <= 1'b0;
      end else begin
         s1_q      <= key_n;
         sync_q    <= s1_q;
         stable_q  <= stable_d;
         deb_cnt_q <= deb_cnt_d;
         state_q   <= state_d;
         timer_q   <= timer_d;
         btn_out_q <= btn_out_d;
         pressed_q <= pressed_d;
      end
   end

   assign btn_out = btn_out_q;
   assign pressed = pressed_q;

endmodule

// File: tb/tb_tetris_key_debounce_repeat.sv
// ---------------------------------------------------------------------------
// tb_tetris_key_debounce_repeat
//
// Drives directed scenarios followed by randomized press/release/bounce
// traffic into tetris_key_debounce_repeat and compares both outputs every
// cycle against an event-scheduled model of the key conditioner.
// ---------------------------------------------------------------------------
module tb_tetris_key_debounce_repeat;

   localparam int DC = 4;
   localparam int RD = 20;
   localparam int RP = 8;
   localparam int GC = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic key_n = 1'b1;
   logic repeat_en = 1'b1;
   logic btn_out;
   logic pressed;

   int vectors = 0;
   int miscompares = 0;

   tetris_key_debounce_repeat #(
      .DEBOUNCE_CYCLES(DC),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP),
      .GAP_CYCLES     (GC)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .key_n    (key_n),
      .repeat_en(repeat_en),
      .btn_out  (btn_out),
      .pressed  (pressed)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Key path: two-sample delay line, then accept a new level once it has
   // disagreed with the accepted level for DC consecutive samples.
   // Repeat path: scheduled in absolute edge numbers. A press is reported
   // on the edge after acceptance; the first gap may begin RD edges later,
   // each gap lasts GC edges, and the next gap may begin RP edges after
   // the previous gap started (provided repeat_en is high at that edge).
   int   now;
   logic m_k [0:1];
   logic m_stable;
   int   m_run;
   logic m_held;
   logic m_in_gap;
   int   m_due;
   int   m_gap_start;
   logic m_btn;
   logic m_pressed;
   logic sync_old;
   logic stable_old;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_k[0]    = 1'b1;
         m_k[1]    = 1'b1;
         m_stable  = 1'b1;
         m_run     = 0;
         m_held    = 1'b0;
         m_in_gap  = 1'b0;
         m_due     = 0;
         m_gap_start = 0;
         m_btn     = 1'b1;
         m_pressed = 1'b0;
         now       = 0;
      end else begin
         sync_old   = m_k[1];
         stable_old = m_stable;
         m_k[1]     = m_k[0];
         m_k[0]     = key_n;

         if (sync_old != m_stable) begin
            m_run = m_run + 1;
            if (m_run == DC) begin
               m_stable = sync_old;
               m_run    = 0;
            end
         end else begin
            m_run = 0;
         end

         m_pressed = ~stable_old;

         if (stable_old) begin
            m_held   = 1'b0;
            m_in_gap = 1'b0;
            m_btn    = 1'b1;
         end else if (!m_held) begin
            m_held = 1'b1;
            m_btn  = 1'b0;
            m_due  = now + RD;
         end else if (m_in_gap) begin
            if (now == m_gap_start + GC) begin
               m_in_gap = 1'b0;
               m_btn    = 1'b0;
               m_due    = m_gap_start + RP;
            end
         end else if (now >= m_due && repeat_en) begin
            m_in_gap    = 1'b1;
            m_btn       = 1'b1;
            m_gap_start = now;
         end
         now = now + 1;
      end
   end

   // ---------------- checking ----------------
   task automatic cmp_model();
      vectors = vectors + 1;
      if (btn_out !== m_btn || pressed !== m_pressed) begin
         miscompares = miscompares + 1;
         $display("FAIL model edge %0d: btn_out=%b pressed=%b, expected btn_out=%b pressed=%b",
                  now, btn_out, pressed, m_btn, m_pressed);
      end
   endtask

   task automatic check_lit(input string name, input logic act, input logic exp);
      vectors = vectors + 1;
      if (act !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Advance n rising edges, sampling 1 time unit after each edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cmp_model();
      end
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #1;
      cmp_model();
      check_lit("reset_btn_out", btn_out, 1'b1);
      check_lit("reset_pressed", pressed, 1'b0);
      tick(3);
      reset_n = 1'b1;
   endtask

   initial begin
      #2;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      cmp_model();
      check_lit("init_btn_out", btn_out, 1'b1);
      check_lit("init_pressed", pressed, 1'b0);
      tick(2);
      reset_n = 1'b1;
      tick(20);

      // 1: clean press with repeat
      repeat_en = 1'b1;
      key_n = 1'b0;
      tick(6);
      check_lit("t1_e6_btn", btn_out, 1'b1);
      check_lit("t1_e6_pressed", pressed, 1'b0);
      tick(1);
      check_lit("t1_e7_btn", btn_out, 1'b0);
      check_lit("t1_e7_pressed", pressed, 1'b1);
      tick(19);
      check_lit("t1_e26_btn", btn_out, 1'b0);
      tick(1);
      check_lit("t1_e27_btn", btn_out, 1'b1);
      tick(1);
      check_lit("t1_e28_btn", btn_out, 1'b1);
      tick(1);
      check_lit("t1_e29_btn", btn_out, 1'b0);
      tick(5);
      check_lit("t1_e34_btn", btn_out, 1'b0);
      tick(1);
      check_lit("t1_e35_btn", btn_out, 1'b1);
      tick(2);
      check_lit("t1_e37_btn", btn_out, 1'b0);
      check_lit("t1_e37_pressed", pressed, 1'b1);
      tick(23);
      key_n = 1'b1;
      tick(20);

      // 2: bounce, runs of 2 never accepted
      for (int i = 0; i < 15; i++) begin
         key_n = ~key_n;
         tick(2);
      end
      key_n = 1'b1;
      tick(20);
      check_lit("t2_btn", btn_out, 1'b1);
      check_lit("t2_pressed", pressed, 1'b0);

      // 3: 3-cycle glitch rejected, 4+ cycles accepted
      key_n = 1'b0;
      tick(3);
      key_n = 1'b1;
      tick(10);
      check_lit("t3_glitch_pressed", pressed, 1'b0);
      check_lit("t3_glitch_btn", btn_out, 1'b1);
      key_n = 1'b0;
      tick(7);
      check_lit("t3_accept_pressed", pressed, 1'b1);
      check_lit("t3_accept_btn", btn_out, 1'b0);
      key_n = 1'b1;
      tick(15);

      // 4: repeat disabled, single falling edge, release after 7 edges
      repeat_en = 1'b0;
      key_n = 1'b0;
      tick(100);
      check_lit("t4_held_btn", btn_out, 1'b0);
      key_n = 1'b1;
      tick(6);
      check_lit("t4_rel6_btn", btn_out, 1'b0);
      tick(1);
      check_lit("t4_rel7_btn", btn_out, 1'b1);
      check_lit("t4_rel7_pressed", pressed, 1'b0);
      tick(10);

      // 5: release during GAP, then during RPT
      repeat_en = 1'b1;
      key_n = 1'b0;
      tick(27);
      check_lit("t5_in_gap_btn", btn_out, 1'b1);
      key_n = 1'b1;
      tick(7);
      check_lit("t5_gap_rel_pressed", pressed, 1'b0);
      check_lit("t5_gap_rel_btn", btn_out, 1'b1);
      tick(20);
      key_n = 1'b0;
      tick(31);
      check_lit("t5_in_rpt_btn", btn_out, 1'b0);
      key_n = 1'b1;
      tick(7);
      check_lit("t5_rpt_rel_pressed", pressed, 1'b0);
      check_lit("t5_rpt_rel_btn", btn_out, 1'b1);
      tick(20);

      // 6: reset during RPT with key held
      key_n = 1'b0;
      tick(31);
      pulse_reset();
      tick(6);
      check_lit("t6_e6_btn", btn_out, 1'b1);
      tick(1);
      check_lit("t6_e7_btn", btn_out, 1'b0);
      check_lit("t6_e7_pressed", pressed, 1'b1);
      key_n = 1'b1;
      tick(15);

      // Randomized traffic
      for (int seg = 0; seg < 120; seg++) begin
         int nb;
         int len;
         nb = $urandom_range(0, 3);
         for (int b = 0; b < nb; b++) begin
            key_n = ~key_n;
            tick($urandom_range(1, 3));
         end
         key_n = ($urandom_range(0, 1) == 0);
         len = $urandom_range(1, 70);
         for (int c = 0; c < len; c++) begin
            if ($urandom_range(0, 19) == 0) begin
               repeat_en = ~repeat_en;
            end
            tick(1);
         end
         if ($urandom_range(0, 29) == 0) begin
            pulse_reset();
         end
      end
      key_n = 1'b1;
      tick(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
